// File: rtl/cic_multichannel.sv
`default_nettype none
// ============================================================================
// cic_multichannel : time-multiplexed, runtime-decimation CIC decimator with
//                    per-channel state, rounding and positive saturation.
// Revision 1.0
// ============================================================================
module cic_multichannel #(
    parameter int STAGES         = 5,
    parameter int NUM_CHANNELS   = 4,
    parameter int MIN_DECIMATION = 2,
    parameter int MAX_DECIMATION = 40,
    parameter int IN_WIDTH       = 18,
    parameter int OUT_WIDTH      = 18,
    parameter int ACC_WIDTH      = IN_WIDTH + STAGES * $clog2(MAX_DECIMATION)
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic [$clog2(MAX_DECIMATION)-1:0]                   decimation,
    input  logic                                                in_strobe,
    input  logic                                                in_sync,
    input  logic signed [IN_WIDTH-1:0]                          in_data,
    output logic                                                out_strobe,
    output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] out_channel,
    output logic signed [OUT_WIDTH-1:0]                         out_data,
    output logic                                                sync_error
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int DA_W = $clog2(MAX_DECIMATION + 1);
    localparam int SW   = $clog2(STAGES + 1);
    localparam int RW   = OUT_WIDTH + 1;

    function automatic logic [DA_W-1:0] clamp_dec(input logic [DA_W-1:0] v);
        if (v < DA_W'(MIN_DECIMATION)) return DA_W'(MIN_DECIMATION);
        if (v > DA_W'(MAX_DECIMATION)) return DA_W'(MAX_DECIMATION);
        return v;
    endfunction

    function automatic int clog2_dec(input logic [DA_W-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i <= DA_W; i++) begin
            if ((1 << i) < int'(v)) r = i + 1;
        end
        return r;
    endfunction

    logic [CH_W-1:0]              ch;
    logic [DA_W-1:0]              sample_no;
    logic [DA_W-1:0]              dec_active;
    logic [SW-1:0]                settle;
    logic signed [ACC_WIDTH-1:0]  integ [STAGES][NUM_CHANNELS];
    logic signed [ACC_WIDTH-1:0]  dly   [STAGES][NUM_CHANNELS];
    logic                         p_valid;
    logic                         p_dec;
    logic                         p_last;
    logic [CH_W-1:0]              p_ch;

    logic [CH_W-1:0]              cur_ch;
    logic                         frame_start;
    logic [DA_W-1:0]              dec_req;
    logic [DA_W-1:0]              dec_eff;
    logic                         reconfig;
    logic                         decimating;
    logic                         last_ch;
    logic signed [ACC_WIDTH-1:0]  comb_c [STAGES+1];
    int                           shift;
    logic signed [RW-1:0]         shifted_lo;
    logic signed [RW-1:0]         rounded;
    logic signed [OUT_WIDTH-1:0]  sat;

    always_comb begin
        cur_ch      = in_sync ? '0 : ch;
        frame_start = in_strobe && (cur_ch == '0) && (sample_no == '0);
        dec_req     = clamp_dec(DA_W'(decimation));
        reconfig    = frame_start && (dec_req != dec_active);
        dec_eff     = frame_start ? dec_req : dec_active;
        decimating  = (sample_no == dec_eff - DA_W'(1));
        last_ch     = (cur_ch == CH_W'(NUM_CHANNELS - 1));
    end

    // Comb ripple for the sample captured on the previous edge, then round and
    // clip; the bit growth of the active rate decides where the output window sits.
    always_comb begin
        comb_c[0] = integ[STAGES-1][p_ch];
        for (int k = 1; k <= STAGES; k++) begin
            comb_c[k] = comb_c[k-1] - dly[k-1][p_ch];
        end
        shift      = IN_WIDTH + STAGES * clog2_dec(dec_active) - 1 - OUT_WIDTH;
        shifted_lo = RW'(comb_c[STAGES] >>> shift);
        rounded    = {shifted_lo[OUT_WIDTH], shifted_lo[OUT_WIDTH:1]}
                   + {{OUT_WIDTH{1'b0}}, shifted_lo[0]};
        if (rounded[OUT_WIDTH] != rounded[OUT_WIDTH-1]) begin
            sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            sat = rounded[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch          <= '0;
            sample_no   <= '0;
            dec_active  <= clamp_dec(DA_W'(decimation));
            settle      <= '0;
            p_valid     <= 1'b0;
            p_dec       <= 1'b0;
            p_last      <= 1'b0;
            p_ch        <= '0;
            out_strobe  <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
            sync_error  <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    integ[s][c] <= '0;
                    dly[s][c]   <= '0;
                end
            end
        end else begin
            sync_error <= in_strobe && in_sync && (ch != '0);
            p_valid    <= in_strobe;
            p_ch       <= cur_ch;
            p_dec      <= decimating;
            p_last     <= last_ch;
            out_strobe <= 1'b0;

            if (p_valid && p_dec) begin
                for (int k = 0; k < STAGES; k++) begin
                    dly[k][p_ch] <= comb_c[k];
                end
                if (settle == '0) begin
                    out_strobe  <= 1'b1;
                    out_channel <= p_ch;
                    out_data    <= sat;
                end else if (p_last) begin
                    settle <= settle - SW'(1);
                end
            end

            // A rate change wipes every channel, overriding the comb write above.
            if (in_strobe) begin
                ch <= last_ch ? '0 : cur_ch + CH_W'(1);
                if (last_ch) sample_no <= decimating ? '0 : sample_no + DA_W'(1);
                if (frame_start) dec_active <= dec_req;
                if (reconfig) begin
                    settle <= SW'(STAGES);
                    for (int s = 0; s < STAGES; s++) begin
                        for (int c = 0; c < NUM_CHANNELS; c++) begin
                            integ[s][c] <= '0;
                            dly[s][c]   <= '0;
                        end
                    end
                    integ[0][0] <= ACC_WIDTH'(in_data);
                end else begin
                    integ[0][cur_ch] <= integ[0][cur_ch] + ACC_WIDTH'(in_data);
                    for (int k = 1; k < STAGES; k++) begin
                        integ[k][cur_ch] <= integ[k][cur_ch] + integ[k-1][cur_ch];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
